// File: rtl/ncl_sync_pkg.sv
// Shared definitions for the dual-rail NCL receiver: rail codes, handshake FSM
// states and the rail-pair decode helper.
package ncl_sync_pkg;

  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_D0   = 2'b01;
  localparam logic [1:0] RAIL_D1   = 2'b10;
  localparam logic [1:0] RAIL_ILL  = 2'b11;

  typedef enum logic [0:0] {
    S_WAIT_DATA = 1'b0,
    S_WAIT_NULL = 1'b1
  } state_t;

  // Only meaningful on a complete wavefront; NULL and ILLEGAL decode to 0.
  function automatic logic rail_bit(input logic [1:0] code);
    return (code == RAIL_D1);
  endfunction

endpackage

// File: rtl/ncl_sync_fifo.sv
// Synchronous FIFO holding single-rail wavefronts ({carry, sum}) until the
// consumer takes them over a valid/ready interface.
module ncl_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ncl_dualrail_sync_receiver.sv
// Clocked receiver closing the NCL counter ring: synchronizes every rail, detects
// complete DATA / NULL wavefronts, buffers DATA words and drives the acknowledge.
module ncl_dualrail_sync_receiver
  import ncl_sync_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [WIDTH-1:0] sum_r1,
  input  logic [WIDTH-1:0] sum_r0,
  input  logic             carry_r1,
  input  logic             carry_r0,
  output logic             ack_o,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_o,
  output logic [15:0]      word_cnt
);

  logic [WIDTH:0] r1_p [SYNC_STAGES];
  logic [WIDTH:0] r0_p [SYNC_STAGES];
  logic [WIDTH:0] r1_s;
  logic [WIDTH:0] r0_s;
  logic [WIDTH:0] word_sl;
  logic [WIDTH:0] fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic           unused_count;
  logic           all_data;
  logic           all_null;
  logic           any_illegal;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           push_ok;
  state_t         state;

  // Synchronizer stages: rails reset to NULL so the ring restarts from a spacer.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r1_p[i] <= '0;
        r0_p[i] <= '0;
      end
    end else begin
      r1_p[0] <= {carry_r1, sum_r1};
      r0_p[0] <= {carry_r0, sum_r0};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r1_p[i] <= r1_p[i-1];
        r0_p[i] <= r0_p[i-1];
      end
    end
  end

  assign r1_s = r1_p[SYNC_STAGES-1];
  assign r0_s = r0_p[SYNC_STAGES-1];

  // Completeness detection on the final-stage sample
  assign all_data    = &(r1_s ^ r0_s);
  assign all_null    = ~|(r1_s | r0_s);
  assign any_illegal = |(r1_s & r0_s);

  always_comb begin
    word_sl = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      word_sl[i] = rail_bit({r1_s[i], r0_s[i]});
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push_ok   = !fifo_full || pop;
  assign push      = (state == S_WAIT_DATA) && all_data && !any_illegal && push_ok;

  ncl_sync_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (init_n),
    .push  (push),
    .pop   (pop),
    .din   (word_sl),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign unused_count = ^fifo_count;
  assign out_data     = fifo_dout[WIDTH-1:0];
  assign out_carry    = fifo_dout[WIDTH];

  // Handshake FSM: ack_o is a flop so the producer never sees a glitch.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= S_WAIT_DATA;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (any_illegal) err_o <= 1'b1;
      case (state)
        S_WAIT_DATA: begin
          if (push) begin
            state    <= S_WAIT_NULL;
            ack_o    <= 1'b1;
            word_cnt <= word_cnt + 1'b1;
          end
        end
        S_WAIT_NULL: begin
          if (all_null) begin
            state <= S_WAIT_DATA;
            ack_o <= 1'b0;
          end
        end
        default: begin
          state <= S_WAIT_DATA;
          ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
